// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM/format enums and the length-field helper.
// Used by the stream padder and the compression core.
package sha256_pkg;

   localparam int         SHA256_BLK_W       = 512;
   localparam int         SHA256_LEN_FIELD_W = 64;
   localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;
   localparam int         SHA256_PAD_THRESH  = 55;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_EMIT = 2'd1,
      ST_PAD2 = 2'd2
   } pad_state_e;

   // FMT_LEN is an all-zero block carrying only the length field.
   typedef enum logic [1:0] {
      FMT_DATA   = 2'd0,
      FMT_PAD    = 2'd1,
      FMT_PADLEN = 2'd2,
      FMT_LEN    = 2'd3
   } fmt_mode_e;

   function automatic logic [SHA256_LEN_FIELD_W-1:0] sha256_len_field(
      input logic [SHA256_LEN_FIELD_W-1:0] byte_cnt);
      return {byte_cnt[SHA256_LEN_FIELD_W-4:0], 3'b000};
   endfunction

endpackage

// File: rtl/sha256_pad_fmt.sv
// Combinational block formatter: overlays the 0x80 marker, zero fill and the
// big-endian bit length onto the collected message bytes.
module sha256_pad_fmt
   import sha256_pkg::*;
(
   input  logic [SHA256_BLK_W-1:0]       data,
   input  logic [5:0]                    idx,
   input  logic [SHA256_LEN_FIELD_W-1:0] len_field,
   input  fmt_mode_e                     mode,
   output logic [SHA256_BLK_W-1:0]       blk
);

   // byte i of the block sits in bits [511-8i -: 8]
   always_comb begin
      blk = data;
      if (mode != FMT_DATA) begin
         for (int i = 0; i < 64; i++) begin
            if ((mode == FMT_LEN) || (i > int'(idx))) begin
               blk[SHA256_BLK_W-1-8*i -: 8] = 8'h00;
            end else if (i == int'(idx)) begin
               blk[SHA256_BLK_W-1-8*i -: 8] = SHA256_PAD_BYTE;
            end else begin
               blk[SHA256_BLK_W-1-8*i -: 8] = data[SHA256_BLK_W-1-8*i -: 8];
            end
         end
         if ((mode == FMT_PADLEN) || (mode == FMT_LEN)) begin
            blk[SHA256_LEN_FIELD_W-1:0] = len_field;
         end else begin
            blk[SHA256_LEN_FIELD_W-1:0] = blk[SHA256_LEN_FIELD_W-1:0];
         end
      end else begin
         blk = data;
      end
   end

endmodule

// File: rtl/sha256_stream_padder.sv
// Byte-stream SHA-256 padder producing 512-bit blocks with first/final flags.
// Optional length check is built when SHA256_PAD_LENCHK_EN is defined.
module sha256_stream_padder
   import sha256_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [7:0]              s_data,
   input  logic                    s_keep,
   input  logic                    s_last,
   output logic                    blk_valid,
   input  logic                    blk_ready,
   output logic [SHA256_BLK_W-1:0] blk_data,
   output logic                    blk_first,
   output logic                    blk_final
`ifdef SHA256_PAD_LENCHK_EN
   ,
   input  logic [LEN_W-1:0]        exp_len,
   output logic                    len_err
`endif
);

   pad_state_e              state_r, state_n;
   logic                    ready_r, ready_n;
   logic [5:0]              idx_r, idx_n;
   logic [LEN_W-1:0]        cnt_r, cnt_n;
   logic [SHA256_BLK_W-1:0] buf_r, buf_n;
   logic                    first_r, first_n;
   logic                    pend_r, pend_n;
   logic                    lead_r, lead_n;
   logic                    blk_valid_r, blk_valid_n;
   logic [SHA256_BLK_W-1:0] blk_data_r, blk_data_n;
   logic                    blk_first_r, blk_first_n;
   logic                    blk_final_r, blk_final_n;

   logic                    accept_s, wr_s, full_s, load_s;
   logic [5:0]              idx_after_s;
   logic [LEN_W-1:0]        cnt_after_s;
   logic [SHA256_BLK_W-1:0] merged_s, fmt_data_s, fmt_blk_s;
   logic [5:0]              fmt_idx_s;
   fmt_mode_e               fmt_mode_s;
   logic [SHA256_LEN_FIELD_W-1:0] len_field_s;

   assign accept_s    = s_valid & ready_r & (state_r == ST_FILL);
   assign wr_s        = accept_s & s_keep;
   assign full_s      = wr_s & (idx_r == 6'd63);
   assign idx_after_s = idx_r + {5'd0, wr_s};
   assign cnt_after_s = cnt_r + LEN_W'(wr_s);
   assign len_field_s = sha256_len_field((state_r == ST_FILL) ?
                                         SHA256_LEN_FIELD_W'(cnt_after_s) :
                                         SHA256_LEN_FIELD_W'(cnt_r));

   // incoming byte merged into the collection buffer
   always_comb begin
      merged_s = buf_r;
      for (int i = 0; i < 64; i++) begin
         if (wr_s && (idx_r == 6'(i))) begin
            merged_s[SHA256_BLK_W-1-8*i -: 8] = s_data;
         end else begin
            merged_s[SHA256_BLK_W-1-8*i -: 8] = buf_r[SHA256_BLK_W-1-8*i -: 8];
         end
      end
   end

   sha256_pad_fmt u_fmt (
      .data      (fmt_data_s),
      .idx       (fmt_idx_s),
      .len_field (len_field_s),
      .mode      (fmt_mode_s),
      .blk       (fmt_blk_s)
   );

   // next-state and block-load decisions
   always_comb begin
      state_n     = state_r;
      ready_n     = ready_r;
      idx_n       = idx_r;
      cnt_n       = cnt_r;
      buf_n       = buf_r;
      first_n     = first_r;
      pend_n      = pend_r;
      lead_n      = lead_r;
      blk_valid_n = blk_valid_r;
      blk_first_n = blk_first_r;
      blk_final_n = blk_final_r;
      load_s      = 1'b0;
      fmt_mode_s  = FMT_DATA;
      fmt_idx_s   = idx_after_s;
      fmt_data_s  = merged_s;
      case (state_r)
         ST_FILL: begin
            ready_n = 1'b1;
            if (accept_s) begin
               buf_n = merged_s;
               idx_n = idx_after_s;
               cnt_n = cnt_after_s;
               if (s_last || full_s) begin
                  load_s  = 1'b1;
                  state_n = ST_EMIT;
                  ready_n = 1'b0;
                  idx_n   = 6'd0;
               end else begin
                  load_s  = 1'b0;
               end
               // a full last block leaves all padding to a second block
               if (s_last && full_s) begin
                  blk_final_n = 1'b0;
                  pend_n      = 1'b1;
                  lead_n      = 1'b1;
               end else if (s_last && (idx_after_s <= 6'(SHA256_PAD_THRESH))) begin
                  fmt_mode_s  = FMT_PADLEN;
                  blk_final_n = 1'b1;
                  pend_n      = 1'b0;
               end else if (s_last) begin
                  fmt_mode_s  = FMT_PAD;
                  blk_final_n = 1'b0;
                  pend_n      = 1'b1;
                  lead_n      = 1'b0;
               end else begin
                  blk_final_n = 1'b0;
                  pend_n      = 1'b0;
               end
            end else begin
               load_s = 1'b0;
            end
         end
         ST_EMIT: begin
            ready_n = 1'b0;
            if (blk_valid_r && blk_ready) begin
               blk_valid_n = 1'b0;
               first_n     = 1'b0;
               if (blk_final_r) begin
                  cnt_n   = {LEN_W{1'b0}};
                  first_n = 1'b1;
                  state_n = ST_FILL;
                  ready_n = 1'b1;
               end else if (pend_r) begin
                  state_n = ST_PAD2;
               end else begin
                  state_n = ST_FILL;
                  ready_n = 1'b1;
               end
            end else begin
               blk_valid_n = blk_valid_r;
            end
         end
         ST_PAD2: begin
            ready_n     = 1'b0;
            load_s      = 1'b1;
            fmt_mode_s  = lead_r ? FMT_PADLEN : FMT_LEN;
            fmt_idx_s   = 6'd0;
            fmt_data_s  = {SHA256_BLK_W{1'b0}};
            blk_final_n = 1'b1;
            pend_n      = 1'b0;
            state_n     = ST_EMIT;
         end
         default: begin
            state_n = ST_FILL;
            ready_n = 1'b0;
         end
      endcase
      if (load_s) begin
         blk_valid_n = 1'b1;
         blk_first_n = first_r;
         blk_data_n  = fmt_blk_s;
      end else begin
         blk_data_n  = blk_data_r;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_FILL;
         ready_r     <= 1'b0;
         idx_r       <= 6'd0;
         cnt_r       <= {LEN_W{1'b0}};
         buf_r       <= {SHA256_BLK_W{1'b0}};
         first_r     <= 1'b1;
         pend_r      <= 1'b0;
         lead_r      <= 1'b0;
         blk_valid_r <= 1'b0;
         blk_data_r  <= {SHA256_BLK_W{1'b0}};
         blk_first_r <= 1'b0;
         blk_final_r <= 1'b0;
      end else begin
         state_r     <= state_n;
         ready_r     <= ready_n;
         idx_r       <= idx_n;
         cnt_r       <= cnt_n;
         buf_r       <= buf_n;
         first_r     <= first_n;
         pend_r      <= pend_n;
         lead_r      <= lead_n;
         blk_valid_r <= blk_valid_n;
         blk_data_r  <= blk_data_n;
         blk_first_r <= blk_first_n;
         blk_final_r <= blk_final_n;
      end
   end

   assign s_ready   = ready_r;
   assign blk_valid = blk_valid_r;
   assign blk_data  = blk_data_r;
   assign blk_first = blk_first_r;
   assign blk_final = blk_final_r;

`ifdef SHA256_PAD_LENCHK_EN
   logic [LEN_W-1:0] exp_r;
   logic [LEN_W-1:0] exp_s;
   logic             len_err_r;
   logic             msg_start_s;

   assign msg_start_s = (cnt_r == {LEN_W{1'b0}});
   assign exp_s       = msg_start_s ? exp_len : exp_r;

   // expected length captured at message start; error sticky until the next one
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_r     <= {LEN_W{1'b0}};
         len_err_r <= 1'b0;
      end else if (accept_s && (s_keep || s_last)) begin
         exp_r     <= exp_s;
         len_err_r <= (msg_start_s ? 1'b0 : len_err_r) |
                      (s_last ? (cnt_after_s != exp_s) : (cnt_after_s > exp_s));
      end else begin
         exp_r     <= exp_r;
         len_err_r <= len_err_r;
      end
   end

   assign len_err = len_err_r;
`else
   // Length check not built: no exp_len/len_err ports.
`endif

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder: reference padding model feeds a
// block scoreboard; a collector thread pops and compares on each transfer.
module tb_sha256_stream_padder;
   import sha256_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic [7:0]   s_data = 8'h00;
   logic         s_keep = 1'b0;
   logic         s_last = 1'b0;
   logic         blk_ready = 1'b0;
   logic         s_ready, blk_valid, blk_first, blk_final;
   logic [511:0] blk_data;

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         fin;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] msg_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   sha256_stream_padder #(.LEN_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_keep    (s_keep),
      .s_last    (s_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_final (blk_final)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference FIPS 180-4 padding of msg_q, split into 64-byte blocks.
   task automatic build_expected();
      logic [7:0]  p[$];
      logic [63:0] bits;
      exp_t        e;
      int          nb;
      p = msg_q;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) << 3;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b+j];
         e.first = (b == 0);
         e.fin   = (b == nb - 1);
         sb.push_back(e);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic drive_beat(input logic [7:0] d, input logic k, input logic l);
      int wc;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      wc = 0;
      @(negedge clk);
      while (!s_ready && wc < 300) begin
         @(negedge clk);
         wc++;
      end
      n_cmp++;
      assert (wc < 300) else begin
         n_err++;
         $error("FAIL beat_timeout observed=%0d expected=<300", wc);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_keep  = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drive_msg();
      if (msg_q.size() == 0) begin
         drive_beat(8'h00, 1'b0, 1'b1);
      end else begin
         for (int i = 0; i < msg_q.size(); i++)
            drive_beat(msg_q[i], 1'b1, (i == msg_q.size() - 1));
      end
   endtask

   task automatic wait_drain();
      int wc;
      wc = 0;
      while (sb.size() != 0 && wc < 600) begin
         @(negedge clk);
         wc++;
      end
      n_cmp++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_collector();
      exp_t e;
      logic want_rdy;
      want_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (want_rdy) check("ready_after_final", {511'd0, s_ready}, 512'd1);
         want_rdy = 1'b0;
         if (!rst && blk_valid && blk_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
               n_err++;
               $error("FAIL unexpected_block observed=%0h expected=none", blk_data);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("blk_data", blk_data, e.data);
               check("blk_first", {511'd0, blk_first}, {511'd0, e.first});
               check("blk_final", {511'd0, blk_final}, {511'd0, e.fin});
               want_rdy = e.fin;
            end
         end
      end
   endtask

   initial begin
      exp_t         e;
      logic [511:0] snap;
      int           wc;

      fork
         run_collector();
      join_none

      rst = 1'b1;
      blk_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", {511'd0, s_ready}, 512'd0);
      check("rst_blk_valid", {511'd0, blk_valid}, 512'd0);
      check("rst_blk_data", blk_data, 512'd0);
      check("rst_flags", {510'd0, blk_first, blk_final}, 512'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wc = 0;
      @(negedge clk);
      while (!s_ready && wc < 5) begin
         @(negedge clk);
         wc++;
      end
      check("ready_after_rst", {511'd0, s_ready}, 512'd1);
      @(posedge clk);
      #1;

      // "abc" against the literal block
      msg_q = '{8'h61, 8'h62, 8'h63};
      e.data  = {8'h61, 8'h62, 8'h63, 8'h80, 416'h0, 64'h18};
      e.first = 1'b1;
      e.fin   = 1'b1;
      sb.push_back(e);
      drive_msg();
      wait_drain();

      // 55, 56, 63, 64, 100 byte messages and the empty message
      msg_q = {};
      for (int i = 0; i < 55; i++) msg_q.push_back(8'(i));
      build_expected(); drive_msg(); wait_drain();
      msg_q.push_back(8'h37);
      build_expected(); drive_msg(); wait_drain();
      for (int i = 56; i < 63; i++) msg_q.push_back(8'(i));
      build_expected(); drive_msg(); wait_drain();
      msg_q.push_back(8'h3f);
      build_expected(); drive_msg(); wait_drain();
      msg_q = {};
      for (int i = 0; i < 100; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      build_expected(); drive_msg(); wait_drain();
      msg_q = {};
      build_expected(); drive_msg(); wait_drain();

      // ignored keep=0 beat mid-message
      msg_q = '{8'h61, 8'h62, 8'h63};
      build_expected();
      drive_beat(8'h61, 1'b1, 1'b0);
      drive_beat(8'h62, 1'b1, 1'b0);
      drive_beat(8'hee, 1'b0, 1'b0);
      drive_beat(8'h63, 1'b1, 1'b1);
      wait_drain();

      // consumer stalls 10 cycles on "abc"
      blk_ready = 1'b0;
      build_expected();
      drive_msg();
      wc = 0;
      @(negedge clk);
      while (!blk_valid && wc < 10) begin
         @(negedge clk);
         wc++;
      end
      check("stall_valid", {511'd0, blk_valid}, 512'd1);
      snap = blk_data;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("stall_data", blk_data, snap);
         check("stall_s_ready", {511'd0, s_ready}, 512'd0);
      end
      @(posedge clk);
      #1;
      blk_ready = 1'b1;
      wait_drain();

      // reset at byte 30, then "abc"
      for (int i = 0; i < 30; i++) drive_beat(8'(i + 16), 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_blk_valid", {511'd0, blk_valid}, 512'd0);
      check("midrst_s_ready", {511'd0, s_ready}, 512'd0);
      @(posedge clk);
      #1;
      msg_q = '{8'h61, 8'h62, 8'h63};
      build_expected();
      drive_msg();
      wait_drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
